tq_dct_ctrl: RTL and testbench
==============================

# tq_dct_ctrl

Sequencer for the forward-transform datapath in the TQ path. It runs one transform unit (TU) through the butterfly/partial-butterfly chain as two passes, rows then columns. It drives per-stage butterfly enables and per-pass shift amounts, and handshakes with the residual fetch upstream and the quantizer downstream. It sits between the TQ top-level control and the combinational butterfly stages plus the transpose buffer.

## Interface
Parameters:
- PIPE_DEPTH, 4, cycles from a row or column entering the butterfly chain to its result being written; sets the drain length after each pass (1..15).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle TU start request; honoured only in IDLE
- tu_size  in  2  TU size, latched at start: 0=4x4, 1=8x8, 2=16x16, 3=32x32
- dst_sel  in  1  use DST for this 4x4 TU; latched at start
- in_valid  in  1  upstream row of residuals valid (row pass)
- in_ready  out  1  controller accepts a row this cycle
- out_ready  in  1  quantizer can accept a column result
- tp_rd_en  out  1  transpose-buffer column read strobe (column pass)
- idx  out  5  current row/column index, 0..N-1
- pass  out  1  0=row pass, 1=column pass
- bfly_en  out  4  stage enables: [3] 32-point stage, [2] 16, [1] 8, [0] 4
- dst_en  out  1  route 4x4 through the DST kernel instead of the butterflies
- shift  out  4  normalization right-shift for the current pass
- busy  out  1  high from the start cycle through the done cycle
- done  out  1  one-cycle pulse when the last column leaves the pipe

## Operation
- N = 4 << tu_size_q.
- States:
  - IDLE: start → ROW. Latch tu_size, dst_sel; idx=0.
  - ROW: in_ready=1. On in_valid&&in_ready, idx++. On handshake with idx==N-1 → RDRAIN, idx=0.
  - RDRAIN: count PIPE_DEPTH cycles → COL.
  - COL: tp_rd_en=out_ready. On tp_rd_en, idx++. On tp_rd_en with idx==N-1 → CDRAIN, idx=0.
  - CDRAIN: count PIPE_DEPTH cycles → DONE.
  - DONE: done=1 for one cycle → IDLE.
- bfly_en is derived from the latched size:
  - 4x4 → 0001
  - 8x8 → 0011
  - 16x16 → 0111
  - 32x32 → 1111
  - Outside ROW/RDRAIN/COL/CDRAIN → 0000. Disabled stages pass data through unchanged.
- shift (8-bit video):
  - pass 0: log2N−1, i.e. 1, 2, 3, 4.
  - pass 1: log2N+6, i.e. 8, 9, 10, 11.
  - IDLE → 0.
- pass = 1 in COL, CDRAIN and DONE; 0 otherwise.
- Boundary conditions:
  - start while busy: ignored; no relatch.
  - in_valid outside ROW: ignored.
  - out_ready low in COL: idx and tp_rd_en hold; no timeout.
  - rst_n low mid-TU: immediate return to IDLE; partial TU discarded.

## Timing
- All outputs are registered or decoded from registered state; there is no input-to-output combinational path except tp_rd_en = (state==COL) & out_ready.
- Reset values:
  - in_ready=0, tp_rd_en=0, idx=0, pass=0, bfly_en=0, dst_en=0, shift=0, busy=0, done=0, state=IDLE.
- start at cycle T → ROW at T+1, with in_ready=1 at T+1.
- Minimum TU latency with no stalls, start to done: 1 + N + PIPE_DEPTH + N + PIPE_DEPTH + 1 cycles.
  - 32x32 with PIPE_DEPTH=4: 74 cycles.
- The drain counter is 4 bits and resets to 0 on entering each drain state.

## Configuration
- TQ_CTRL_DST_EN defined:
  - When latched tu_size==0 and dst_sel==1: dst_en=1 and bfly_en=0000 for the whole TU.
  - Shifts are unchanged (1 / 8).
- TQ_CTRL_DST_EN undefined:
  - dst_sel is ignored, dst_en is tied to 0, and 4x4 always uses the butterflies.

## Test plan
- Reset, then 32x32 TU with in_valid and out_ready held at 1, PIPE_DEPTH=4 → bfly_en=1111; shift=4 then 11; 32 in_ready handshakes; 32 tp_rd_en strobes; done exactly 74 cycles after start; idle state and outputs back at reset values.
- 4x4 TU with in_valid toggling 1,0,1,0 → idx advances only on handshakes; exactly 4 row accepts; shift=1 then 8; bfly_en=0001.
- 16x16 column pass with out_ready low for 5 cycles at idx=7 → tp_rd_en=0 and idx holds at 7 for those 5 cycles; completes with 16 strobes total.
- start pulsed again mid-ROW of an 8x8 TU, with tu_size changed to 3 → ignored; the TU finishes with N=8 and bfly_en=0011.
- rst_n asserted during COL at idx=10 → all outputs 0 asynchronously; the next start runs a clean TU from idx=0.
- With TQ_CTRL_DST_EN defined: 4x4 TU with dst_sel=1 → dst_en=1, bfly_en=0000. Without the macro → dst_en=0, bfly_en=0001.

Source files
------------

// File: rtl/tq_dct_ctrl_if.sv
// Handshake and control bundle between TQ control, residual fetch, quantizer and the
// forward-transform sequencer. The slave modport is the sequencer side.
`timescale 1ns / 1ps
interface tq_dct_ctrl_if;
  logic       start;
  logic [1:0] tu_size;
  logic       dst_sel;
  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       tp_rd_en;
  logic [4:0] idx;
  logic       pass;
  logic [3:0] bfly_en;
  logic       dst_en;
  logic [3:0] shift;
  logic       busy;
  logic       done;

  modport master (
    output start, tu_size, dst_sel, in_valid, out_ready,
    input  in_ready, tp_rd_en, idx, pass, bfly_en, dst_en, shift, busy, done
  );

  modport slave (
    input  start, tu_size, dst_sel, in_valid, out_ready,
    output in_ready, tp_rd_en, idx, pass, bfly_en, dst_en, shift, busy, done
  );
endinterface

// File: rtl/tq_dct_ctrl.sv
// Forward-transform sequencer: row pass, drain, column pass, drain, done.
// Optional DST routing for 4x4 TUs is enabled by defining TQ_CTRL_DST_EN.
`timescale 1ns / 1ps
module tq_dct_ctrl #(
  parameter int unsigned PIPE_DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  tq_dct_ctrl_if.slave bus
);
  typedef enum logic [2:0] {StIdle, StRow, StRdrain, StCol, StCdrain, StDone} state_e;

  localparam logic [3:0] DrainLast = 4'(PIPE_DEPTH - 1);

  state_e     state_q, state_d;
  logic [1:0] size_q, size_d;
  logic       dst_q, dst_d, dst_req;
  logic [4:0] idx_q, idx_d, last_idx;
  logic [3:0] cnt_q, cnt_d;
  logic       in_ready, tp_rd_en, busy, active, pass;
  logic [3:0] bfly_en, shift;

`ifdef TQ_CTRL_DST_EN
  assign dst_req = bus.dst_sel & (bus.tu_size == 2'd0);
`else
  logic unused_dst_sel;
  assign unused_dst_sel = bus.dst_sel;
  assign dst_req        = 1'b0;
`endif

  assign last_idx = 5'((6'd4 << size_q) - 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      size_q  <= 2'd0;
      dst_q   <= 1'b0;
      idx_q   <= 5'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      dst_q   <= dst_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    dst_d    = dst_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    tp_rd_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRow;
          size_d  = bus.tu_size;
          dst_d   = dst_req;
          idx_d   = 5'd0;
        end
      end
      StRow: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (idx_q == last_idx) begin
            state_d = StRdrain;
            idx_d   = 5'd0;
            cnt_d   = 4'd0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StRdrain: begin
        if (cnt_q == DrainLast) state_d = StCol;
        else cnt_d = cnt_q + 4'd1;
      end
      StCol: begin
        tp_rd_en = bus.out_ready;
        if (bus.out_ready) begin
          if (idx_q == last_idx) begin
            state_d = StCdrain;
            idx_d   = 5'd0;
            cnt_d   = 4'd0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StCdrain: begin
        if (cnt_q == DrainLast) state_d = StDone;
        else cnt_d = cnt_q + 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy   = (state_q != StIdle);
  assign active = (state_q == StRow) || (state_q == StRdrain) ||
                  (state_q == StCol) || (state_q == StCdrain);
  assign pass   = (state_q == StCol) || (state_q == StCdrain) || (state_q == StDone);

  // Stage enables form a thermometer code: 1, 3, 7, 15 for 4..32 points.
  always_comb begin
    bfly_en = 4'd0;
    if (active && !dst_q) bfly_en = 4'((5'd2 << size_q) - 5'd1);
  end

  always_comb begin
    shift = 4'd0;
    if (busy) shift = pass ? (4'd8 + {2'b00, size_q}) : (4'd1 + {2'b00, size_q});
  end

  assign bus.in_ready = in_ready;
  assign bus.tp_rd_en = tp_rd_en;
  assign bus.idx      = idx_q;
  assign bus.pass     = pass;
  assign bus.bfly_en  = bfly_en;
  assign bus.dst_en   = dst_q & busy;
  assign bus.shift    = shift;
  assign bus.busy     = busy;
  assign bus.done     = (state_q == StDone);
endmodule

// File: tb/tb_tq_dct_ctrl.sv
// Directed bench for tq_dct_ctrl: one task per scenario, inputs driven and outputs
// sampled just after the falling edge.
`timescale 1ns / 1ps
module tb_tq_dct_ctrl;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  tq_dct_ctrl_if bus ();

  tq_dct_ctrl #(.PIPE_DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [18:0] snap;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.tu_size = 2'd0; bus.dst_sel = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    snap = {bus.in_ready, bus.tp_rd_en, bus.idx, bus.pass, bus.bfly_en, bus.dst_en,
            bus.shift, bus.busy, bus.done};
    checks++;
    if (snap !== 19'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", snap);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_32x32();
    int cyc = 1, rows = 0, cols = 0, bad_bfly = 0, bad_shift = 0;
    bit seen_done = 0, first_ok = 0;
    logic [18:0] snap;
    @(negedge clk);
    bus.start = 1'b1; bus.tu_size = 2'd3; bus.dst_sel = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    while (!seen_done && cyc < 200) begin
      @(negedge clk); bus.start = 1'b0; #1; cyc++;
      if (cyc == 2) first_ok = bus.in_ready && bus.busy && (bus.idx == 5'd0);
      if (bus.in_ready && bus.in_valid) rows++;
      if (bus.tp_rd_en) cols++;
      if (bus.in_ready && bus.shift !== 4'd4) bad_shift++;
      if (bus.tp_rd_en && bus.shift !== 4'd11) bad_shift++;
      if (bus.done) seen_done = 1;
      else if (bus.bfly_en !== 4'b1111) bad_bfly++;
    end
    checks++;
    if (!seen_done) begin errors++; $display("FAIL s32_done: timeout after %0d cycles", cyc); end
    checks++;
    if (!first_ok) begin errors++; $display("FAIL s32_first_row: in_ready/busy/idx wrong at T+1"); end
    // Cycle count includes the start cycle and the done cycle.
    checks++;
    if (cyc !== 74) begin errors++; $display("FAIL s32_latency: got %0d expected 74", cyc); end
    checks++;
    if (rows !== 32) begin errors++; $display("FAIL s32_rows: got %0d expected 32", rows); end
    checks++;
    if (cols !== 32) begin errors++; $display("FAIL s32_cols: got %0d expected 32", cols); end
    checks++;
    if (bad_bfly !== 0) begin errors++; $display("FAIL s32_bfly: %0d bad cycles expected 0", bad_bfly); end
    checks++;
    if (bad_shift !== 0) begin errors++; $display("FAIL s32_shift: %0d bad cycles expected 0", bad_shift); end
    @(negedge clk); #1;
    snap = {bus.in_ready, bus.tp_rd_en, bus.idx, bus.pass, bus.bfly_en, bus.dst_en,
            bus.shift, bus.busy, bus.done};
    checks++;
    if (snap !== 19'd0) begin errors++; $display("FAIL s32_idle: got %h expected 0", snap); end
  endtask

  task automatic test_4x4_toggle();
    int cyc = 1, rows = 0, bad_idx = 0, bad_shift = 0, bad_bfly = 0;
    logic [4:0] exp_idx = 5'd0;
    bit seen_done = 0;
    logic tog = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.tu_size = 2'd0; bus.dst_sel = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    while (!seen_done && cyc < 100) begin
      @(negedge clk); bus.start = 1'b0; bus.in_valid = tog; tog = ~tog; #1; cyc++;
      if (bus.in_ready) begin
        if (bus.idx !== exp_idx) bad_idx++;
        if (bus.shift !== 4'd1) bad_shift++;
        if (bus.in_valid) begin rows++; exp_idx++; end
      end
      if (bus.tp_rd_en && bus.shift !== 4'd8) bad_shift++;
      if (bus.done) seen_done = 1;
      else if (bus.bfly_en !== 4'b0001) bad_bfly++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!seen_done) begin errors++; $display("FAIL s4_done: timeout after %0d cycles", cyc); end
    checks++;
    if (rows !== 4) begin errors++; $display("FAIL s4_rows: got %0d expected 4", rows); end
    checks++;
    if (bad_idx !== 0) begin errors++; $display("FAIL s4_idx: %0d bad cycles expected 0", bad_idx); end
    checks++;
    if (bad_shift !== 0) begin errors++; $display("FAIL s4_shift: %0d bad cycles expected 0", bad_shift); end
    checks++;
    if (bad_bfly !== 0) begin errors++; $display("FAIL s4_bfly: %0d bad cycles expected 0", bad_bfly); end
    // Seven row cycles for four accepts: 1 + 7 + 4 + 4 + 4 + 1.
    checks++;
    if (cyc !== 21) begin errors++; $display("FAIL s4_latency: got %0d expected 21", cyc); end
  endtask

  task automatic test_16x16_stall();
    int cyc = 1, strobes = 0, stall_left = 5, stalled = 0, bad = 0, bad_col = 0;
    logic [4:0] exp_col = 5'd0;
    bit seen_done = 0, in_col;
    @(negedge clk);
    bus.start = 1'b1; bus.tu_size = 2'd2; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    while (!seen_done && cyc < 200) begin
      @(negedge clk); bus.start = 1'b0;
      in_col = bus.pass && !bus.done && (strobes < 16);
      bus.out_ready = !(in_col && bus.idx == 5'd7 && stall_left > 0);
      #1; cyc++;
      if (!bus.out_ready) begin
        stalled++; stall_left--;
        if (bus.tp_rd_en !== 1'b0 || bus.idx !== 5'd7) bad++;
      end
      if (bus.tp_rd_en) begin
        strobes++;
        if (bus.idx !== exp_col) bad_col++;
        exp_col++;
      end
      if (bus.done) seen_done = 1;
    end
    bus.out_ready = 1'b1;
    checks++;
    if (!seen_done) begin errors++; $display("FAIL s16_done: timeout after %0d cycles", cyc); end
    checks++;
    if (stalled !== 5) begin errors++; $display("FAIL s16_stalled: got %0d expected 5", stalled); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL s16_hold: %0d bad stall cycles expected 0", bad); end
    checks++;
    if (bad_col !== 0) begin errors++; $display("FAIL s16_col_idx: %0d bad strobes expected 0", bad_col); end
    checks++;
    if (strobes !== 16) begin errors++; $display("FAIL s16_strobes: got %0d expected 16", strobes); end
    checks++;
    if (cyc !== 47) begin errors++; $display("FAIL s16_latency: got %0d expected 47", cyc); end
  endtask

  task automatic test_restart_ignored();
    int cyc = 1, rows = 0, cols = 0, bad_bfly = 0;
    bit seen_done = 0, pulsed = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.tu_size = 2'd1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    while (!seen_done && cyc < 200) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.in_ready && bus.idx == 5'd3 && !pulsed) begin
        bus.start = 1'b1; bus.tu_size = 2'd3; pulsed = 1;
      end
      #1; cyc++;
      if (bus.in_ready && bus.in_valid) rows++;
      if (bus.tp_rd_en) cols++;
      if (bus.done) seen_done = 1;
      else if (bus.bfly_en !== 4'b0011) bad_bfly++;
    end
    bus.start = 1'b0;
    checks++;
    if (!(seen_done && pulsed)) begin
      errors++; $display("FAIL s8_done: done=%0d pulsed=%0d expected 1 1", seen_done, pulsed);
    end
    checks++;
    if (rows !== 8) begin errors++; $display("FAIL s8_rows: got %0d expected 8", rows); end
    checks++;
    if (cols !== 8) begin errors++; $display("FAIL s8_cols: got %0d expected 8", cols); end
    checks++;
    if (bad_bfly !== 0) begin errors++; $display("FAIL s8_bfly: %0d bad cycles expected 0", bad_bfly); end
    checks++;
    if (cyc !== 26) begin errors++; $display("FAIL s8_latency: got %0d expected 26", cyc); end
    @(negedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL s8_idle_after: busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int cyc = 1, rows = 0, cols = 0;
    bit found = 0, seen_done = 0, first_ok = 0;
    logic [18:0] snap;
    @(negedge clk);
    bus.start = 1'b1; bus.tu_size = 2'd2; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    while (!found && cyc < 200) begin
      @(negedge clk); bus.start = 1'b0; #1; cyc++;
      if (bus.tp_rd_en && bus.idx == 5'd10) found = 1;
    end
    #2 rst_n = 1'b0;
    #1;
    snap = {bus.in_ready, bus.tp_rd_en, bus.idx, bus.pass, bus.bfly_en, bus.dst_en,
            bus.shift, bus.busy, bus.done};
    checks++;
    if (!found || snap !== 19'd0) begin
      errors++; $display("FAIL mid_reset: found=%0d outputs=%h expected 1 and 0", found, snap);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.tu_size = 2'd0; cyc = 1;
    while (!seen_done && cyc < 100) begin
      @(negedge clk); bus.start = 1'b0; #1; cyc++;
      if (cyc == 2) first_ok = bus.in_ready && (bus.idx == 5'd0) && !bus.pass;
      if (bus.in_ready && bus.in_valid) rows++;
      if (bus.tp_rd_en) cols++;
      if (bus.done) seen_done = 1;
    end
    checks++;
    if (!first_ok) begin errors++; $display("FAIL post_reset_first_row: bad state at T+1"); end
    checks++;
    if (rows !== 4 || cols !== 4) begin
      errors++; $display("FAIL post_reset_counts: rows=%0d cols=%0d expected 4 4", rows, cols);
    end
    checks++;
    if (!seen_done || cyc !== 18) begin
      errors++; $display("FAIL post_reset_latency: got %0d expected 18", cyc);
    end
  endtask

  task automatic test_dst();
    int cyc = 1, bad = 0;
    bit seen_done = 0;
`ifdef TQ_CTRL_DST_EN
    logic       exp_dst  = 1'b1;
    logic [3:0] exp_bfly = 4'b0000;
`else
    logic       exp_dst  = 1'b0;
    logic [3:0] exp_bfly = 4'b0001;
`endif
    @(negedge clk);
    bus.start = 1'b1; bus.tu_size = 2'd0; bus.dst_sel = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    while (!seen_done && cyc < 100) begin
      @(negedge clk); bus.start = 1'b0; #1; cyc++;
      if (bus.dst_en !== exp_dst) bad++;
      if (bus.done) seen_done = 1;
      else if (bus.bfly_en !== exp_bfly) bad++;
      if (bus.in_ready && bus.shift !== 4'd1) bad++;
      if (bus.tp_rd_en && bus.shift !== 4'd8) bad++;
    end
    bus.dst_sel = 1'b0;
    checks++;
    if (!seen_done || bad !== 0) begin
      errors++; $display("FAIL dst_tu: done=%0d bad=%0d expected 1 0", seen_done, bad);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.dst_en !== 1'b0) begin errors++; $display("FAIL dst_idle: got %b expected 0", bus.dst_en); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_32x32();
    test_4x4_toggle();
    test_16x16_stall();
    test_restart_ignored();
    test_reset_mid();
    test_dst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
